rob_param: RTL and testbench
============================

# rob_param

Parametrised reorder buffer for the out-of-order RISC-V core, sitting between dispatch, the RS/ALU and LSB writeback buses, the register file and fetch. It allocates one tag per dispatched instruction, captures results from two writeback ports, forwards ready operands to dispatch, and retires entries in program order. At retirement it drives register write-back, store release, IO-load release and mispredict flush/redirect. Compared with the fixed 16-entry ROB, it adds:
- configurable depth and widths;
- explicit head/tail pointers with wrap bits;
- a commit-tag output;
- same-cycle writeback forwarding on operand lookups;
- a sticky overflow flag.

## Interface
Parameters:
- DEPTH, 16, entry count; power of two, 4..64
- TAG_W, log2(DEPTH), tag width
- XLEN, 32, data/address width
- REG_W, 5, architectural register index width
- FULL_MARGIN, 3, `rob_full` asserts when count ≥ DEPTH−FULL_MARGIN

Ports:
- clk_in  in  1  clock, rising edge
- rst_n_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global enable; when 0, all state holds and outputs keep their values
- disp_valid  in  1  allocate an entry this cycle
- disp_is_store, disp_is_load  in  1 each  instruction class
- disp_npc  in  XLEN  predicted next PC
- disp_rd  in  REG_W  destination register; 0 = none
- alu_valid, alu_tag, alu_val, alu_npc  in  1/TAG_W/XLEN/XLEN  ALU writeback with resolved next PC
- lsb_valid, lsb_tag, lsb_val  in  1/TAG_W/XLEN  load writeback
- q1_valid, q1_tag / q2_valid, q2_tag  in  1/TAG_W  operand lookups; q*_valid=0 means no dependency
- q1_ready, q1_val / q2_ready, q2_val  out  1/XLEN  lookup results
- next_tag  out  TAG_W  tag given to the next dispatch (= tail index)
- head_tag  out  TAG_W  oldest entry index
- count  out  TAG_W+1  occupied entries
- rob_full, rob_empty  out  1  status
- commit_valid, commit_tag, commit_rd, commit_val  out  1/TAG_W/REG_W/XLEN  registered retirement; commit_rd=0 means no register write
- store_release  out  1  pulse: head store may write memory
- io_enable  out  1  pulse: head load may perform IO access
- flush, flush_pc  out  1/XLEN  registered redirect pulse and target
- overflow  out  1  sticky; set by dispatch while count==DEPTH

## Operation
- Each entry holds: state (EMPTY/ISSUED/DONE), is_store, is_load, npc, new_npc, rd, val.
- Pointers head and tail are TAG_W+1 bits; the MSB is the wrap bit.
  - count = tail−head (modulo 2^(TAG_W+1)).
  - Empty when head==tail; full when the indices are equal and the wrap bits differ.
- **Dispatch** (disp_valid and count<DEPTH):
  - entry[tail] ← ISSUED, new_npc←disp_npc, val←0; tail+1.
  - If count==DEPTH: dispatch is dropped, overflow set, no state change.
- **Writeback**:
  - ALU: entry[alu_tag] ← DONE with val and new_npc.
  - LSB: entry[lsb_tag] ← DONE with val; new_npc unchanged.
  - Both ports may fire in the same cycle on distinct tags. Writeback to an EMPTY entry is ignored.
- **Commit** (at most one per cycle, evaluated on registered state):
  - Head DONE:
    - Pop the entry; commit_valid=1 next cycle with tag/rd/val.
    - If new_npc≠npc, flush=1 and flush_pc=new_npc next cycle.
  - Head ISSUED and is_store: pop; store_release pulse; commit_valid=1 with rd=0.
  - Head ISSUED, is_load, no lsb writeback this cycle, io_wait=0: io_enable pulse, io_wait←1. io_wait clears on the next pop.
- **Flush**: in any cycle where registered flush==1:
  - All entries go EMPTY; head=tail=0; io_wait=0.
  - Dispatch and writeback are ignored that cycle.
  - overflow is unaffected.
- **Lookup** (combinational): q*_ready=1 if:
  - q*_valid=0 (val=0); or
  - entry DONE; or
  - a same-cycle alu/lsb writeback matches the tag. ALU has priority if both match (illegal in practice).

## Timing
- Reset (async, rst_n_in=0):
  - All outputs 0 except rob_empty=1.
  - Pointers 0, all entries EMPTY, io_wait=0, overflow=0.
- Dispatch → next_tag advances next cycle.
- Writeback → earliest commit of that entry is the next cycle, so result-to-commit_valid latency is 2 cycles minimum.
- commit_valid, store_release, io_enable and flush are single-cycle pulses, cleared each active cycle unless re-asserted.
- Pointer wrap: tail DEPTH−1 → 0 with wrap bit toggled. Full is distinguished from empty by the wrap bit.
- Pop and dispatch in the same cycle leave count unchanged. Dispatch is legal when count==DEPTH−1, even with a pop in the same cycle.
- Reset deasserted mid-stream: the block resumes from the empty state.

## Test plan
- **Reset, then one ALU op:**
  - Stimulus: reset; dispatch rd=5, npc=0x104; ALU writeback val=0x55, alu_npc=0x104.
  - Required: commit_valid with rd=5, val=0x55 two cycles after writeback; no flush.
- **Mispredict:**
  - Stimulus: dispatch 3 entries; head gets alu_npc=0x200 ≠ npc=0x108.
  - Required: flush=1, flush_pc=0x200; next cycle rob_empty=1, next_tag=0; later writebacks to old tags are ignored.
- **Fill and wrap (DEPTH=16):**
  - Stimulus: dispatch 16 entries; then a 17th dispatch; then retire all.
  - Required: count=16; rob_full high from count 13; the 17th dispatch sets overflow and is dropped; after retiring, next_tag wraps to 0 and a new dispatch gets tag 0.
- **Store and IO load:**
  - Stimulus: a store at head; then a load at head with no LSB response.
  - Required: store_release one pulse with commit rd=0; io_enable exactly one pulse while waiting; LSB writeback later commits the load.
- **Forwarding:**
  - Stimulus: q1_tag=3 in the same cycle as alu_tag=3, val=0x77.
  - Required: q1_ready=1, q1_val=0x77 combinationally.
  - Stimulus: q2_valid=0. Required: q2_ready=1.
- **Simultaneous events:**
  - Stimulus: commit, dispatch, ALU and LSB writebacks all in one cycle.
  - Required: count unchanged; both entries marked DONE.

Source files
------------

// File: rtl/rob_param.sv
// rob_param: reorder buffer; allocates tags, captures ALU/LSB writebacks, forwards operands, retires in order.
// Latency: dispatch->next_tag 1 cycle; writeback->commit_valid 2 cycles min; operand lookups combinational.
// Backpressure: rdy_in=0 freezes all state; dispatch while full is dropped and sets sticky overflow.
module rob_param #(
  parameter int DEPTH       = 16,
  parameter int TAG_W       = $clog2(DEPTH),
  parameter int XLEN        = 32,
  parameter int REG_W       = 5,
  parameter int FULL_MARGIN = 3
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             disp_valid,
  input  logic             disp_is_store,
  input  logic             disp_is_load,
  input  logic [XLEN-1:0]  disp_npc,
  input  logic [REG_W-1:0] disp_rd,
  input  logic             alu_valid,
  input  logic [TAG_W-1:0] alu_tag,
  input  logic [XLEN-1:0]  alu_val,
  input  logic [XLEN-1:0]  alu_npc,
  input  logic             lsb_valid,
  input  logic [TAG_W-1:0] lsb_tag,
  input  logic [XLEN-1:0]  lsb_val,
  input  logic             q1_valid,
  input  logic [TAG_W-1:0] q1_tag,
  input  logic             q2_valid,
  input  logic [TAG_W-1:0] q2_tag,
  output logic             q1_ready,
  output logic [XLEN-1:0]  q1_val,
  output logic             q2_ready,
  output logic [XLEN-1:0]  q2_val,
  output logic [TAG_W-1:0] next_tag,
  output logic [TAG_W-1:0] head_tag,
  output logic [TAG_W:0]   count,
  output logic             rob_full,
  output logic             rob_empty,
  output logic             commit_valid,
  output logic [TAG_W-1:0] commit_tag,
  output logic [REG_W-1:0] commit_rd,
  output logic [XLEN-1:0]  commit_val,
  output logic             store_release,
  output logic             io_enable,
  output logic             flush,
  output logic [XLEN-1:0]  flush_pc,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ISSUED = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [TAG_W:0] PTR_ONE = (TAG_W+1)'(1);
  localparam logic [TAG_W:0] CNT_MAX = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] FULL_TH = (TAG_W+1)'(DEPTH - FULL_MARGIN);

  state_t           st        [DEPTH];
  logic             is_st     [DEPTH];
  logic             is_ld     [DEPTH];
  logic [XLEN-1:0]  npc_q     [DEPTH];
  logic [XLEN-1:0]  new_npc_q [DEPTH];
  logic [XLEN-1:0]  val_q     [DEPTH];
  logic [REG_W-1:0] rd_q      [DEPTH];

  // Pointers carry a wrap bit above the index so full and empty are distinguishable.
  logic [TAG_W:0]   head, tail;
  logic             io_wait;
  logic [TAG_W:0]   occ;
  logic [TAG_W-1:0] head_idx, tail_idx;
  logic             do_disp, pop_done, pop_store, do_pop, io_fire;

  assign occ       = tail - head;
  assign head_idx  = head[TAG_W-1:0];
  assign tail_idx  = tail[TAG_W-1:0];
  assign count     = occ;
  assign next_tag  = tail_idx;
  assign head_tag  = head_idx;
  assign rob_empty = (head == tail);
  assign rob_full  = (occ >= FULL_TH);

  // Retirement decisions look only at registered entry state, never at this cycle's writebacks.
  assign do_disp   = disp_valid && (occ != CNT_MAX);
  assign pop_done  = (st[head_idx] == ST_DONE);
  assign pop_store = (st[head_idx] == ST_ISSUED) && is_st[head_idx];
  assign do_pop    = pop_done || pop_store;
  assign io_fire   = (st[head_idx] == ST_ISSUED) && !is_st[head_idx] && is_ld[head_idx] &&
                     !lsb_valid && !io_wait;

  // Operand lookup: a same-cycle writeback beats the stored value, ALU before LSB.
  function automatic logic [XLEN:0] lookup(input logic qv, input logic [TAG_W-1:0] qt);
    logic [XLEN:0] r;
    r = '0;
    if (!qv)                              r = {1'b1, {XLEN{1'b0}}};
    else if (alu_valid && alu_tag == qt)  r = {1'b1, alu_val};
    else if (lsb_valid && lsb_tag == qt)  r = {1'b1, lsb_val};
    else if (st[qt] == ST_DONE)           r = {1'b1, val_q[qt]};
    return r;
  endfunction

  // Combinational operand forwarding for both dispatch source operands.
  always_comb begin
    {q1_ready, q1_val} = lookup(q1_valid, q1_tag);
    {q2_ready, q2_val} = lookup(q2_valid, q2_tag);
  end

  // Entry storage, pointers, retirement pulses and flush recovery.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head          <= '0;
      tail          <= '0;
      io_wait       <= 1'b0;
      overflow      <= 1'b0;
      commit_valid  <= 1'b0;
      commit_tag    <= '0;
      commit_rd     <= '0;
      commit_val    <= '0;
      store_release <= 1'b0;
      io_enable     <= 1'b0;
      flush         <= 1'b0;
      flush_pc      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        st[i]        <= ST_EMPTY;
        is_st[i]     <= 1'b0;
        is_ld[i]     <= 1'b0;
        npc_q[i]     <= '0;
        new_npc_q[i] <= '0;
        val_q[i]     <= '0;
        rd_q[i]      <= '0;
      end
    end else if (rdy_in) begin
      commit_valid  <= 1'b0;
      store_release <= 1'b0;
      io_enable     <= 1'b0;
      flush         <= 1'b0;
      if (flush) begin
        // Redirect cycle: discard everything younger than the mispredicted branch.
        head    <= '0;
        tail    <= '0;
        io_wait <= 1'b0;
        for (int i = 0; i < DEPTH; i++) st[i] <= ST_EMPTY;
      end else begin
        if (alu_valid && st[alu_tag] != ST_EMPTY) begin
          st[alu_tag]        <= ST_DONE;
          val_q[alu_tag]     <= alu_val;
          new_npc_q[alu_tag] <= alu_npc;
        end
        if (lsb_valid && st[lsb_tag] != ST_EMPTY) begin
          st[lsb_tag]    <= ST_DONE;
          val_q[lsb_tag] <= lsb_val;
        end
        // Pop comes after writeback so a late writeback cannot resurrect the retiring entry.
        if (do_pop) begin
          st[head_idx]  <= ST_EMPTY;
          head          <= head + PTR_ONE;
          io_wait       <= 1'b0;
          commit_valid  <= 1'b1;
          commit_tag    <= head_idx;
          commit_rd     <= pop_store ? '0 : rd_q[head_idx];
          commit_val    <= val_q[head_idx];
          store_release <= pop_store;
          if (pop_done && (new_npc_q[head_idx] != npc_q[head_idx])) begin
            flush    <= 1'b1;
            flush_pc <= new_npc_q[head_idx];
          end
        end else if (io_fire) begin
          io_enable <= 1'b1;
          io_wait   <= 1'b1;
        end
        if (do_disp) begin
          st[tail_idx]        <= ST_ISSUED;
          is_st[tail_idx]     <= disp_is_store;
          is_ld[tail_idx]     <= disp_is_load;
          npc_q[tail_idx]     <= disp_npc;
          new_npc_q[tail_idx] <= disp_npc;
          rd_q[tail_idx]      <= disp_rd;
          val_q[tail_idx]     <= '0;
          tail                <= tail + PTR_ONE;
        end
        if (disp_valid && !do_disp) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// tb_rob_param: scoreboard bench for rob_param (DEPTH=16).
// Expected commits are queued at dispatch, values filled at writeback, popped on commit_valid.
// Inputs driven 1 ns after the rising edge; outputs sampled there or on the falling edge.
`timescale 1ns/1ps
module tb_rob_param;
  localparam int DEPTH = 16;
  localparam int TAG_W = 4;
  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  logic             clk_in = 1'b0;
  logic             rst_n_in = 1'b0;
  logic             rdy_in = 1'b1;
  logic             disp_valid = 1'b0, disp_is_store = 1'b0, disp_is_load = 1'b0;
  logic [XLEN-1:0]  disp_npc = '0;
  logic [REG_W-1:0] disp_rd = '0;
  logic             alu_valid = 1'b0;
  logic [TAG_W-1:0] alu_tag = '0;
  logic [XLEN-1:0]  alu_val = '0, alu_npc = '0;
  logic             lsb_valid = 1'b0;
  logic [TAG_W-1:0] lsb_tag = '0;
  logic [XLEN-1:0]  lsb_val = '0;
  logic             q1_valid = 1'b0, q2_valid = 1'b0;
  logic [TAG_W-1:0] q1_tag = '0, q2_tag = '0;
  logic             q1_ready, q2_ready;
  logic [XLEN-1:0]  q1_val, q2_val;
  logic [TAG_W-1:0] next_tag, head_tag, commit_tag;
  logic [TAG_W:0]   count;
  logic             rob_full, rob_empty, commit_valid, store_release, io_enable, flush, overflow;
  logic [REG_W-1:0] commit_rd;
  logic [XLEN-1:0]  commit_val, flush_pc;

  rob_param dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .disp_valid(disp_valid), .disp_is_store(disp_is_store), .disp_is_load(disp_is_load),
    .disp_npc(disp_npc), .disp_rd(disp_rd),
    .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_val(alu_val), .alu_npc(alu_npc),
    .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_val(lsb_val),
    .q1_valid(q1_valid), .q1_tag(q1_tag), .q2_valid(q2_valid), .q2_tag(q2_tag),
    .q1_ready(q1_ready), .q1_val(q1_val), .q2_ready(q2_ready), .q2_val(q2_val),
    .next_tag(next_tag), .head_tag(head_tag), .count(count),
    .rob_full(rob_full), .rob_empty(rob_empty),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
    .commit_val(commit_val), .store_release(store_release), .io_enable(io_enable),
    .flush(flush), .flush_pc(flush_pc), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_pass = 0;
  int exp_q[$];
  int m_tail = 0;
  logic [REG_W-1:0] m_rd  [DEPTH];
  logic [XLEN-1:0]  m_val [DEPTH];
  logic [XLEN-1:0]  m_npc [DEPTH];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic disp_drive(input logic s, input logic l, input logic [REG_W-1:0] rd,
                            input logic [XLEN-1:0] npc);
    m_rd[m_tail]  = s ? '0 : rd;
    m_val[m_tail] = '0;
    m_npc[m_tail] = npc;
    exp_q.push_back(m_tail);
    m_tail = (m_tail + 1) % DEPTH;
    disp_valid = 1'b1; disp_is_store = s; disp_is_load = l; disp_rd = rd; disp_npc = npc;
  endtask

  task automatic dispatch(input logic s, input logic l, input logic [REG_W-1:0] rd,
                          input logic [XLEN-1:0] npc);
    disp_drive(s, l, rd, npc);
    tick();
    disp_valid = 1'b0; disp_is_store = 1'b0; disp_is_load = 1'b0;
  endtask

  task automatic alu_wb(input int tag, input logic [XLEN-1:0] v);
    m_val[tag] = v;
    alu_valid = 1'b1; alu_tag = TAG_W'(tag); alu_val = v; alu_npc = m_npc[tag];
    tick();
    alu_valid = 1'b0;
  endtask

  task automatic lsb_wb(input int tag, input logic [XLEN-1:0] v);
    m_val[tag] = v;
    lsb_valid = 1'b1; lsb_tag = TAG_W'(tag); lsb_val = v;
    tick();
    lsb_valid = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (!rob_empty && n < budget) begin
      tick();
      n++;
    end
    if (!rob_empty) chk("wait_empty_timeout", 1'b0, 1'b1);
  endtask

  // Commit monitor: every commit must match the oldest outstanding dispatch.
  always @(negedge clk_in) begin
    int t;
    if (rst_n_in && rdy_in && commit_valid) begin
      if (exp_q.size() == 0) chk("commit_unexpected", 1'b1, 1'b0);
      else begin
        t = exp_q.pop_front();
        chk("commit_tag", commit_tag, t);
        chk("commit_rd", commit_rd, m_rd[t]);
        chk("commit_val", commit_val, m_val[t]);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_io;
    for (int i = 0; i < DEPTH; i++) begin
      m_rd[i] = '0; m_val[i] = '0; m_npc[i] = '0;
    end
    repeat (3) @(posedge clk_in);
    #1;
    // Reset state
    chk("rst_empty", rob_empty, 1'b1);
    chk("rst_count", count, 0);
    chk("rst_next_tag", next_tag, 0);
    chk("rst_commit_valid", commit_valid, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_full", rob_full, 1'b0);
    chk("rst_io_store", {io_enable, store_release}, 2'b00);
    rst_n_in = 1'b1;
    tick();

    // One ALU op: commit two cycles after writeback, no flush
    dispatch(1'b0, 1'b0, 5'd5, 32'h104);
    chk("t1_next_tag", next_tag, 1);
    alu_wb(0, 32'h55);
    chk("t1_commit_not_yet", commit_valid, 1'b0);
    tick();
    chk("t1_commit_valid", commit_valid, 1'b1);
    chk("t1_no_flush", flush, 1'b0);

    // Mispredict on head tag 1
    dispatch(1'b0, 1'b0, 5'd1, 32'h108);
    dispatch(1'b0, 1'b0, 5'd2, 32'h10c);
    dispatch(1'b0, 1'b0, 5'd3, 32'h110);
    m_val[1] = 32'hAA;
    alu_valid = 1'b1; alu_tag = 4'd1; alu_val = 32'hAA; alu_npc = 32'h200;
    tick();
    alu_valid = 1'b0;
    tick();
    chk("mp_flush", flush, 1'b1);
    chk("mp_flush_pc", flush_pc, 32'h200);
    disp_valid = 1'b1; disp_rd = 5'd3; disp_npc = 32'h999;
    tick();
    disp_valid = 1'b0;
    exp_q.delete();
    m_tail = 0;
    chk("mp_empty", rob_empty, 1'b1);
    chk("mp_next_tag", next_tag, 0);
    chk("mp_count", count, 0);
    chk("mp_flush_cleared", flush, 1'b0);
    q1_valid = 1'b1; q1_tag = 4'd2;
    #1;
    chk("mp_old_lookup", q1_ready, 1'b0);
    q1_valid = 1'b0;
    alu_valid = 1'b1; alu_tag = 4'd2; alu_val = 32'h99; alu_npc = 32'h10c;
    tick();
    alu_valid = 1'b0;
    tick();
    chk("mp_stale_wb_empty", rob_empty, 1'b1);
    chk("mp_overflow_clear", overflow, 1'b0);

    // Fill, overflow, retire, wrap
    for (int i = 0; i < DEPTH; i++) begin
      dispatch(1'b0, 1'b0, REG_W'(i + 1), 32'h1000 + 32'(4 * i));
      chk("fill_count", count, i + 1);
      chk("fill_full", rob_full, (i + 1) >= 13);
    end
    disp_valid = 1'b1; disp_rd = 5'd31; disp_npc = 32'hdead;
    tick();
    disp_valid = 1'b0;
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_count", count, 16);
    chk("ovf_not_empty", rob_empty, 1'b0);
    chk("ovf_next_tag", next_tag, 0);
    for (int i = 0; i < DEPTH; i++) alu_wb(i, 32'h100 + 32'(i));
    wait_empty(40);
    chk("wrap_next_tag", next_tag, 0);
    chk("wrap_head_tag", head_tag, 0);
    chk("wrap_full_low", rob_full, 1'b0);

    // Store at head: single store_release with rd=0, lands on tag 0 after wrap
    dispatch(1'b1, 1'b0, 5'd7, 32'h2000);
    chk("st_tag0_used", next_tag, 1);
    chk("st_rel_early", store_release, 1'b0);
    tick();
    chk("st_rel_pulse", store_release, 1'b1);
    chk("st_commit", commit_valid, 1'b1);
    tick();
    chk("st_rel_drop", store_release, 1'b0);

    // IO load: exactly one io_enable while waiting, then LSB completes it
    dispatch(1'b0, 1'b1, 5'd9, 32'h3000);
    n_io = 0;
    repeat (6) begin
      if (io_enable) n_io++;
      tick();
    end
    chk("io_pulses", n_io, 1);
    chk("io_still_pending", rob_empty, 1'b0);
    lsb_wb(1, 32'hBEEF);
    wait_empty(10);
    chk("io_no_flush", flush, 1'b0);

    // Forwarding
    dispatch(1'b0, 1'b0, 5'd10, 32'h4000);
    dispatch(1'b0, 1'b0, 5'd11, 32'h4004);
    dispatch(1'b0, 1'b0, 5'd12, 32'h4008);
    dispatch(1'b0, 1'b0, 5'd13, 32'h400c);
    m_val[3] = 32'h77;
    alu_valid = 1'b1; alu_tag = 4'd3; alu_val = 32'h77; alu_npc = m_npc[3];
    q1_valid = 1'b1; q1_tag = 4'd3; q2_valid = 1'b0;
    #1;
    chk("fwd_q1_ready", q1_ready, 1'b1);
    chk("fwd_q1_val", q1_val, 32'h77);
    chk("fwd_q2_nodep_ready", q2_ready, 1'b1);
    chk("fwd_q2_nodep_val", q2_val, 32'h0);
    q2_valid = 1'b1; q2_tag = 4'd4;
    #1;
    chk("fwd_q2_pending", q2_ready, 1'b0);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("fwd_q1_stored", {q1_ready, q1_val}, {1'b1, 32'h77});
    q1_valid = 1'b0; q2_valid = 1'b0;
    alu_wb(2, 32'h22);

    // Simultaneous commit + dispatch + ALU + LSB
    chk("sim_count_before", count, 4);
    disp_drive(1'b0, 1'b0, 5'd14, 32'h4010);
    m_val[4] = 32'h44; m_val[5] = 32'h45;
    alu_valid = 1'b1; alu_tag = 4'd4; alu_val = 32'h44; alu_npc = m_npc[4];
    lsb_valid = 1'b1; lsb_tag = 4'd5; lsb_val = 32'h45;
    tick();
    disp_valid = 1'b0; alu_valid = 1'b0; lsb_valid = 1'b0;
    chk("sim_count_after", count, 4);
    chk("sim_commit", commit_valid, 1'b1);
    q1_valid = 1'b1; q1_tag = 4'd4; q2_valid = 1'b1; q2_tag = 4'd5;
    #1;
    chk("sim_done_alu", {q1_ready, q1_val}, {1'b1, 32'h44});
    chk("sim_done_lsb", {q2_ready, q2_val}, {1'b1, 32'h45});
    q1_valid = 1'b0; q2_valid = 1'b0;
    lsb_wb(6, 32'h66);
    wait_empty(20);
    tick();

    // Global enable low freezes the pointers
    rdy_in = 1'b0;
    disp_valid = 1'b1; disp_rd = 5'd1; disp_npc = 32'h7000;
    tick();
    chk("rdy_hold_tag", next_tag, m_tail);
    chk("rdy_hold_count", count, 0);
    disp_valid = 1'b0;
    rdy_in = 1'b1;
    tick();

    // Mid-stream reset resumes empty
    dispatch(1'b0, 1'b0, 5'd3, 32'h5000);
    dispatch(1'b0, 1'b0, 5'd4, 32'h5004);
    rst_n_in = 1'b0;
    #2;
    chk("mrst_empty", rob_empty, 1'b1);
    chk("mrst_tag", next_tag, 0);
    chk("mrst_overflow", overflow, 1'b0);
    exp_q.delete();
    m_tail = 0;
    rst_n_in = 1'b1;
    tick();
    dispatch(1'b0, 1'b0, 5'd4, 32'h6000);
    chk("mrst_first_tag", next_tag, 1);
    alu_wb(0, 32'h12);
    wait_empty(10);
    tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
